// File: rtl/gener_check.sv
// gener_check: receive side of the rtt_probe generator, sitting in the user data path.
// Probe packets (fixed MACs, ethertype 0x0801, fixed body pattern) are recognised, checked,
// counted as good or bad and dropped. All other packets pass through unchanged and in order.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   in_*                upstream pipeline (in_rdy = input fifo not nearly full)
//   out_*               downstream pipeline (out_wr only while out_rdy)
//   reg_*_in/reg_*_out  register ring; this block answers requests whose tag matches
//                       GENER_CHK_BLOCK_ADDR
//
// Register map (offset within the block)
//   0 good probe counter   1 bad probe counter   2 ctrl (bit0 = enable, read/write)
//   3 status               4 gap (cycles between the last two good probes)
module gener_check #(
  parameter int DATA_WIDTH               = 64,
  parameter int CTRL_WIDTH               = DATA_WIDTH / 8,
  parameter int UDP_REG_SRC_WIDTH        = 2,
  parameter int UDP_REG_ADDR_WIDTH       = 23,
  parameter int GENER_CHK_REG_ADDR_WIDTH = 4,
  parameter int GENER_CHK_BLOCK_ADDR     = 'h00101
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [CTRL_WIDTH-1:0]         in_ctrl,
  input  logic                          in_wr,
  output logic                          in_rdy,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [CTRL_WIDTH-1:0]         out_ctrl,
  output logic                          out_wr,
  input  logic                          out_rdy,
  input  logic                          reg_req_in,
  input  logic                          reg_ack_in,
  input  logic                          reg_rd_wr_L_in,
  input  logic [UDP_REG_ADDR_WIDTH-1:0] reg_addr_in,
  input  logic [31:0]                   reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]  reg_src_in,
  output logic                          reg_req_out,
  output logic                          reg_ack_out,
  output logic                          reg_rd_wr_L_out,
  output logic [UDP_REG_ADDR_WIDTH-1:0] reg_addr_out,
  output logic [31:0]                   reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]  reg_src_out
);

  localparam logic [63:0] PROBE_WORD1 = 64'h0011_2233_4455_0011;
  localparam logic [47:0] PROBE_WORD2 = 48'h2233_4455_0801;
  localparam logic [63:0] PROBE_BODY  = 64'h0011_2233_4455_6677;
  localparam int          RAW         = GENER_CHK_REG_ADDR_WIDTH;
  localparam int          TAG_W       = UDP_REG_ADDR_WIDTH - RAW;
  localparam logic [TAG_W-1:0] BLOCK_TAG = TAG_W'(GENER_CHK_BLOCK_ADDR);

  // ---------------------------------------------------------------- input fifo
  // Four-entry fall-through fifo: the head word is visible while not empty.
  logic [DATA_WIDTH+CTRL_WIDTH-1:0] fifo_mem [0:3];
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] fifo_cnt_q, fifo_cnt_d;
  logic       fifo_empty, fifo_push, rd_en;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;

  assign fifo_empty = (fifo_cnt_q == 3'd0);
  assign fifo_push  = in_wr && (fifo_cnt_q != 3'd4) && !reset;
  // Nearly full at three entries leaves room for a write already in flight.
  assign in_rdy     = !reset && (fifo_cnt_q < 3'd3);
  assign {head_ctrl, head_data} = fifo_mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q + {1'b0, fifo_push};
    rd_ptr_d   = rd_ptr_q + {1'b0, rd_en};
    fifo_cnt_d = fifo_cnt_q + {2'b0, fifo_push} - {2'b0, rd_en};
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr_q] <= {in_ctrl, in_data};
  end

  // ---------------------------------------------------------------- probe fsm
  // One-hot with an all-zero idle state so it fits the 4-bit status field.
  typedef enum logic [3:0] {
    S_WAIT_HDR = 4'b0000,
    S_HOLD     = 4'b0001,
    S_FLUSH    = 4'b0010,
    S_THRU     = 4'b0100,
    S_CHECK    = 4'b1000
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] hold_data_q [0:3];
  logic [63:0] hold_data_d [0:3];
  logic [7:0]  hold_ctrl_q [0:3];
  logic [7:0]  hold_ctrl_d [0:3];
  logic [1:0]  hold_cnt_q, hold_cnt_d, flush_idx_q, flush_idx_d;
  logic        err_q, err_d, err_acc, word_match;
  logic [15:0] wcnt_q, wcnt_d, wcnt_inc, len_words;
  logic        wcnt_sat;
  logic        good_q, good_d, bad_q, bad_d;
  logic        enable;
  logic        fwd_wr;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [CTRL_WIDTH-1:0] fwd_ctrl;

  assign len_words = hold_data_q[0][47:32];
  assign wcnt_sat  = (wcnt_q == 16'hffff);
  assign wcnt_inc  = wcnt_sat ? wcnt_q : wcnt_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    flush_idx_d = flush_idx_q;
    err_d       = err_q;
    wcnt_d      = wcnt_q;
    good_d      = 1'b0;
    bad_d       = 1'b0;
    rd_en       = 1'b0;
    fwd_wr      = 1'b0;
    fwd_data    = head_data;
    fwd_ctrl    = head_ctrl;
    err_acc     = err_q;
    word_match  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hold_data_d[i] = hold_data_q[i];
      hold_ctrl_d[i] = hold_ctrl_q[i];
    end

    case (state_q)
      S_WAIT_HDR: begin
        if (!fifo_empty) begin
          if (enable) begin
            rd_en          = 1'b1;
            hold_data_d[0] = head_data;
            hold_ctrl_d[0] = head_ctrl;
            hold_cnt_d     = 2'd1;
            err_d          = 1'b0;
            wcnt_d         = 16'd0;
            state_d        = S_HOLD;
          end else if (out_rdy) begin
            rd_en   = 1'b1;
            fwd_wr  = 1'b1;
            state_d = S_THRU;
          end
        end
      end

      S_HOLD: begin
        if (!fifo_empty) begin
          rd_en                   = 1'b1;
          hold_data_d[hold_cnt_q] = head_data;
          hold_ctrl_d[hold_cnt_q] = head_ctrl;
          hold_cnt_d              = hold_cnt_q + 2'd1;
          if (hold_cnt_q == 2'd1)
            word_match = (head_ctrl == '0) && (head_data == PROBE_WORD1);
          else
            word_match = (head_ctrl == '0) && (head_data[63:16] == PROBE_WORD2);
          if (!word_match) begin
            flush_idx_d = 2'd0;
            state_d     = S_FLUSH;
          end else if (hold_cnt_q == 2'd2) begin
            // word1 and word2 are the first two counted data words
            wcnt_d  = 16'd2;
            state_d = S_CHECK;
          end
        end
      end

      S_FLUSH: begin
        fwd_data = hold_data_q[flush_idx_q];
        fwd_ctrl = hold_ctrl_q[flush_idx_q];
        if (out_rdy) begin
          fwd_wr = 1'b1;
          if (flush_idx_q == hold_cnt_q - 2'd1) begin
            // A held end word means the packet is already complete.
            state_d    = (hold_ctrl_q[flush_idx_q] != '0) ? S_WAIT_HDR : S_THRU;
            hold_cnt_d = 2'd0;
          end else begin
            flush_idx_d = flush_idx_q + 2'd1;
          end
        end
      end

      S_THRU: begin
        if (!fifo_empty && out_rdy) begin
          rd_en  = 1'b1;
          fwd_wr = 1'b1;
          if (head_ctrl != '0) state_d = S_WAIT_HDR;
        end
      end

      S_CHECK: begin
        if (!fifo_empty) begin
          rd_en   = 1'b1;
          wcnt_d  = wcnt_inc;
          err_acc = err_q | wcnt_sat;
          if (head_ctrl != '0) begin
            if ((head_ctrl != 8'hff) || (head_data != 64'h0)) err_acc = 1'b1;
            if ({1'b0, wcnt_inc} != ({1'b0, len_words} + 17'd1)) err_acc = 1'b1;
            good_d     = !err_acc;
            bad_d      = err_acc;
            err_d      = 1'b0;
            wcnt_d     = 16'd0;
            hold_cnt_d = 2'd0;
            state_d    = S_WAIT_HDR;
          end else begin
            if (head_data != PROBE_BODY) err_acc = 1'b1;
            err_d = err_acc;
          end
        end
      end

      default: state_d = S_WAIT_HDR;
    endcase
  end

  // Forwarded words leave in the same cycle they are popped or replayed.
  assign out_wr   = fwd_wr && !reset;
  assign out_data = reset ? '0 : fwd_data;
  assign out_ctrl = reset ? '0 : fwd_ctrl;

  // Hold registers carry data only; their validity is tracked by hold_cnt.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      hold_data_q[i] <= hold_data_d[i];
      hold_ctrl_q[i] <= hold_ctrl_d[i];
    end
  end

  // ---------------------------------------------------------------- counters
  logic [31:0] good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;
  logic [31:0] gap_cnt_q, gap_cnt_d, gap_q, gap_d;
  logic [31:0] ctrl_q, ctrl_d, status;

  assign enable = ctrl_q[0];
  assign status = {16'h0, len_words[7:0], hold_cnt_q, fifo_empty, out_rdy, state_q};

  always_comb begin
    good_cnt_d = good_cnt_q + {31'b0, good_q};
    bad_cnt_d  = bad_cnt_q + {31'b0, bad_q};
    // gap counter restarts at 1 so the next good probe reports the exact cycle distance
    if (good_q) begin
      gap_cnt_d = 32'd1;
      gap_d     = gap_cnt_q;
    end else begin
      gap_cnt_d = (gap_cnt_q == 32'hffff_ffff) ? gap_cnt_q : gap_cnt_q + 32'd1;
      gap_d     = gap_q;
    end
  end

  // ---------------------------------------------------------------- register ring
  logic                          reg_req_q, reg_req_d, reg_ack_q, reg_ack_d;
  logic                          reg_rd_wr_L_q, reg_rd_wr_L_d;
  logic [UDP_REG_ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [31:0]                   reg_data_q, reg_data_d, reg_rdata;
  logic [UDP_REG_SRC_WIDTH-1:0]  reg_src_q, reg_src_d;
  logic [RAW-1:0]                reg_offset;
  logic                          tag_hit;

  assign reg_offset = reg_addr_in[RAW-1:0];
  assign tag_hit    = (reg_addr_in[UDP_REG_ADDR_WIDTH-1:RAW] == BLOCK_TAG);

  always_comb begin
    if      (reg_offset == RAW'(0)) reg_rdata = good_cnt_q;
    else if (reg_offset == RAW'(1)) reg_rdata = bad_cnt_q;
    else if (reg_offset == RAW'(2)) reg_rdata = ctrl_q;
    else if (reg_offset == RAW'(3)) reg_rdata = status;
    else if (reg_offset == RAW'(4)) reg_rdata = gap_q;
    else                            reg_rdata = 32'hdead_beef;
  end

  always_comb begin
    reg_req_d     = reg_req_in;
    reg_ack_d     = reg_ack_in;
    reg_rd_wr_L_d = reg_rd_wr_L_in;
    reg_addr_d    = reg_addr_in;
    reg_data_d    = reg_data_in;
    reg_src_d     = reg_src_in;
    ctrl_d        = ctrl_q;
    if (reg_req_in && !reg_ack_in && tag_hit) begin
      reg_ack_d = 1'b1;
      if (reg_rd_wr_L_in)               reg_data_d = reg_rdata;
      else if (reg_offset == RAW'(2))   ctrl_d     = reg_data_in;
    end
  end

  assign reg_req_out     = reg_req_q;
  assign reg_ack_out     = reg_ack_q;
  assign reg_rd_wr_L_out = reg_rd_wr_L_q;
  assign reg_addr_out    = reg_addr_q;
  assign reg_data_out    = reg_data_q;
  assign reg_src_out     = reg_src_q;

  // ---------------------------------------------------------------- state flops
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      state_q       <= S_WAIT_HDR;
      hold_cnt_q    <= '0;
      flush_idx_q   <= '0;
      err_q         <= 1'b0;
      wcnt_q        <= '0;
      good_q        <= 1'b0;
      bad_q         <= 1'b0;
      good_cnt_q    <= '0;
      bad_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      gap_q         <= '0;
      ctrl_q        <= '0;
      reg_req_q     <= 1'b0;
      reg_ack_q     <= 1'b0;
      reg_rd_wr_L_q <= 1'b0;
      reg_addr_q    <= '0;
      reg_data_q    <= '0;
      reg_src_q     <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      flush_idx_q   <= flush_idx_d;
      err_q         <= err_d;
      wcnt_q        <= wcnt_d;
      good_q        <= good_d;
      bad_q         <= bad_d;
      good_cnt_q    <= good_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      gap_q         <= gap_d;
      ctrl_q        <= ctrl_d;
      reg_req_q     <= reg_req_d;
      reg_ack_q     <= reg_ack_d;
      reg_rd_wr_L_q <= reg_rd_wr_L_d;
      reg_addr_q    <= reg_addr_d;
      reg_data_q    <= reg_data_d;
      reg_src_q     <= reg_src_d;
    end
  end

endmodule
